// File: rtl/knn_sched_if.sv
// knn_sched_if: requester, knn_core and result signals of the measurement scheduler
interface knn_sched_if #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic                en;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    stop;
    logic [N_REQ-1:0]    gnt;
    logic                knn_enable;
    logic                knn_sample;
    logic [2*DATA_W-1:0] knn_value;
    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [2*DATA_W-1:0] res_elapsed;
    logic                res_ready;

    modport master (
        output en, req, stop, knn_value, res_ready,
        input  gnt, knn_enable, knn_sample, res_valid, res_id, res_elapsed
    );

    modport slave (
        input  en, req, stop, knn_value, res_ready,
        output gnt, knn_enable, knn_sample, res_valid, res_id, res_elapsed
    );
endinterface

// File: rtl/knn_sched.sv
// knn_sched: round-robin scheduler timing one requester at a time on a shared knn_core counter
module knn_sched #(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input logic       clk,
    input logic       rst,
    knn_sched_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START_SMP = 3'd1;
    localparam logic [2:0] GRANT     = 3'd2;
    localparam logic [2:0] STOP_SMP  = 3'd3;
    localparam logic [2:0] STOP_CAP  = 3'd4;
    localparam logic [2:0] RESULT    = 3'd5;

    logic [2:0]          state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     cur_id;
    logic [ID_W-1:0]     nxt_id;
    logic                found;
    logic                first;
    logic [2*DATA_W-1:0] start_ts;

    // Scan downward so the requester closest to ptr is the last (winning) assignment
    always_comb begin
        int idx;
        found  = 1'b0;
        nxt_id = ptr;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (bus.req[idx]) begin
                found  = 1'b1;
                nxt_id = ID_W'(idx);
            end
        end
    end

    assign bus.gnt        = (state == GRANT) ? (N_REQ'(1) << cur_id) : '0;
    assign bus.knn_sample = (state == START_SMP) || (state == STOP_SMP);
    assign bus.res_valid  = (state == RESULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            cur_id          <= '0;
            first           <= 1'b0;
            start_ts        <= '0;
            bus.knn_enable  <= 1'b0;
            bus.res_id      <= '0;
            bus.res_elapsed <= '0;
        end else begin
            bus.knn_enable <= bus.en;
            case (state)
                IDLE: if (found) begin
                    cur_id <= nxt_id;
                    ptr    <= (nxt_id == ID_W'(N_REQ - 1)) ? '0 : nxt_id + 1'b1;
                    state  <= START_SMP;
                end
                START_SMP: begin
                    first <= 1'b1;
                    state <= GRANT;
                end
                GRANT: begin
                    first <= 1'b0;
                    if (first) start_ts <= bus.knn_value;
                    if (bus.stop[cur_id] || !bus.req[cur_id]) state <= STOP_SMP;
                end
                STOP_SMP: state <= STOP_CAP;
                STOP_CAP: begin
                    bus.res_elapsed <= bus.knn_value - start_ts;
                    bus.res_id      <= cur_id;
                    state           <= RESULT;
                end
                RESULT: if (bus.res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/knn_sched.md
# knn_sched

Measurement scheduler for the shared `knn_core` time counter. Up to N_REQ requesters compete for the single counter through a round-robin arbiter. For the granted requester the block takes a start timestamp and a stop timestamp using `knn_core`'s sample/value port. It returns the modular difference with the requester id over a valid/ready result port. It sits between the requester engines and one `knn_core` instance, and drives that instance's enable and sample inputs.

## Interface
- DATA_W, 32: `knn_core` data width; timestamps and results are 2*DATA_W bits.
- N_REQ, 4: number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ): requester id width.

- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  counter run request; registered and driven to knn_enable.
- req  in  N_REQ  per-requester level request.
- stop  in  N_REQ  per-requester end-of-measurement pulse; only the granted bit is honoured.
- gnt  out  N_REQ  one-hot grant, or all zero.
- knn_enable  out  1  to `knn_core` KNN_ENABLE.
- knn_sample  out  1  to `knn_core` KNN_SAMPLE; single-cycle pulse.
- knn_value  in  2*DATA_W  from `knn_core` KNN_VALUE; sampled register, valid the cycle after knn_sample.
- res_valid  out  1  result available.
- res_id  out  ID_W  id of the measured requester.
- res_elapsed  out  2*DATA_W  stop_ts - start_ts.
- res_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, START_SMP, GRANT, STOP_SMP, STOP_CAP, RESULT.
- IDLE:
  - If any req is high, select an id by round-robin, starting the search at ptr.
  - Latch the id in cur_id and go to START_SMP.
  - ptr resets to 0. On each selection, ptr = cur_id+1 mod N_REQ.
- START_SMP: knn_sample=1; go to GRANT.
- GRANT:
  - gnt[cur_id]=1.
  - On the first GRANT cycle, start_ts <= knn_value.
  - If stop[cur_id], or !req[cur_id] (abort), go to STOP_SMP.
  - stop[cur_id] wins over a simultaneous req drop; both end the measurement identically.
- STOP_SMP: knn_sample=1; gnt=0; go to STOP_CAP.
- STOP_CAP: compute res_elapsed = knn_value - start_ts, mod 2^(2*DATA_W), and register it; go to RESULT.
- RESULT:
  - res_valid=1; res_id and res_elapsed are held stable.
  - When res_ready is high, go to IDLE.
  - No new grant is issued until the result is accepted.
- Bits of stop other than cur_id are ignored at all times, as is stop in every state other than GRANT.
- Counter wrap-around between the start and stop samples gives the correct modular difference; there is no overflow flag.
- If en falls during a measurement, the counter freezes, so res_elapsed counts only enabled cycles.
- Requests that arrive during a measurement wait. There is no queue beyond the req levels themselves.

## Timing
- Reset values:
  - gnt=0, knn_enable=0, knn_sample=0.
  - res_valid=0, res_id=0, res_elapsed=0.
  - state=IDLE, ptr=0, start_ts=0.
- knn_enable = en delayed by one cycle.
- Let s be the START_SMP cycle and k the cycle in which stop[cur_id] is seen in GRANT. Then:
  - gnt rises at s+1 and falls at k+1.
  - STOP_SMP occurs at k+1.
  - With en steady high, res_elapsed = k+1-s, so the minimum value is 2.
- Latency from req in IDLE (cycle r) to gnt is 2 cycles: START_SMP at r+1, gnt at r+2.
- Latency from stop to res_valid is 3 cycles: STOP_SMP, STOP_CAP, then RESULT at k+3.
- With res_ready held high, RESULT lasts one cycle. The next grant can then rise 3 cycles after res_valid.
- Reset asserted mid-operation forces IDLE and all reset values on the next edge. Any in-flight result is discarded. `knn_core` shares rst, so the counter also clears.

## Test plan
- Single requester:
  - Stimulus: en=1 from reset, req[2]=1 at cycle 10, stop[2] pulsed 10 cycles after gnt[2] rises.
  - Required: gnt[2] high for 11 cycles; res_valid with res_id=2 and res_elapsed=12.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held; every grant stopped after 3 cycles; res_ready=1.
  - Required: grant order 0,1,2,3,0; every res_elapsed=5.
- Wrap-around:
  - Stimulus: force start_ts=2^64-3 via preload of the `knn_core` counter; measurement with raw stop sample 4.
  - Required: res_elapsed=7.
- Abort and ignored stops:
  - Stimulus: req[1] drops at the 5th GRANT cycle; stop[0] and stop[3] pulsed during GRANT.
  - Required: stray stops have no effect; res_id=1, res_elapsed=6.
- Backpressure and en freeze:
  - Stimulus: en=0 for 4 cycles mid-GRANT; res_ready=0 for 8 cycles.
  - Required: res_elapsed reduced by 4 versus the steady-en case; res_valid and data held stable; no gnt until res_ready.
- Reset mid-GRANT:
  - Stimulus: rst pulsed during GRANT.
  - Required: next cycle all outputs are at reset values and state is IDLE; a subsequent req[0] is served normally.
